// File: rtl/fdc_sector_reader.sv
// Read-sector engine for the virtual floppy drive: finds the requested sector under the
// head and turns each data byte into a DRQ carrying the matching disk-image byte address.
module fdc_sector_reader #(
  parameter int SECTOR_LEN    = 1024,
  parameter int SPT           = 5,
  parameter int SIDES         = 2,
  parameter int SECTOR_BASE   = 0,
  parameter int INDEX_TIMEOUT = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic        cmd_abort,
  input  logic [6:0]  cmd_track,
  input  logic [3:0]  cmd_sector,
  input  logic        cmd_side,
  input  logic        fd_ready,
  input  logic        fd_dclk_en,
  input  logic [6:0]  fd_track,
  input  logic [3:0]  fd_sector,
  input  logic        fd_sector_hdr,
  input  logic        fd_sector_data,
  input  logic        fd_index,
  output logic        busy,
  output logic        drq,
  input  logic        data_ack,
  output logic [19:0] img_addr,
  output logic        done,
  output logic        err_rnf,
  output logic        err_lost,
  output logic        err_notready
);

  localparam int OFF_W = $clog2(SECTOR_LEN);
  localparam int IDX_W = $clog2(INDEX_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_XFER,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [6:0]        trk_q, trk_d;
  logic [3:0]        sec_q, sec_d;
  logic              side_q, side_d;
  logic              busy_q, busy_d;
  logic              drq_q, drq_d;
  logic [19:0]       img_addr_q, img_addr_d;
  logic              done_q, done_d;
  logic              err_rnf_q, err_rnf_d;
  logic              err_lost_q, err_lost_d;
  logic              err_nr_q, err_nr_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [IDX_W-1:0]  idx_cnt_q, idx_cnt_d;
  logic              idx_q, hdr_q;

  logic        index_edge, hdr_match, deliver, last_byte;
  logic [19:0] base;

  // Image layout is track-major, then side, then sector; wraps modulo 2^20.
  assign base = ((20'(trk_q) * 20'(SIDES) + 20'(side_q)) * 20'(SPT)
                 + 20'(sec_q) - 20'(SECTOR_BASE)) * 20'(SECTOR_LEN);

  assign index_edge = idx_q & ~fd_index;
  assign hdr_match  = fd_sector_hdr & ~hdr_q & (fd_track == trk_q) & (fd_sector == sec_q);
  assign deliver    = fd_dclk_en & fd_sector_data;
  assign last_byte  = (offset_q == {OFF_W{1'b1}});

  always_comb begin
    // NOTE: every *_d gets its hold value first so no path through the case infers a latch.
    state_d    = state_q;
    trk_d      = trk_q;
    sec_d      = sec_q;
    side_d     = side_q;
    busy_d     = busy_q;
    drq_d      = drq_q;
    img_addr_d = img_addr_q;
    done_d     = 1'b0;
    err_rnf_d  = err_rnf_q;
    err_lost_d = err_lost_q;
    err_nr_d   = err_nr_q;
    offset_d   = offset_q;
    idx_cnt_d  = idx_cnt_q;

    if (cmd_abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      drq_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_start) begin
            trk_d      = cmd_track;
            sec_d      = cmd_sector;
            side_d     = cmd_side;
            busy_d     = 1'b1;
            err_rnf_d  = 1'b0;
            err_lost_d = 1'b0;
            err_nr_d   = !fd_ready;
            offset_d   = '0;
            idx_cnt_d  = '0;
            state_d    = fd_ready ? S_SEARCH : S_FINISH;
          end
        end
        S_SEARCH: begin
          if (!fd_ready) begin
            err_nr_d = 1'b1;
            drq_d    = 1'b0;
            state_d  = S_FINISH;
          end else if (hdr_match) begin
            offset_d = '0;
            state_d  = S_XFER;
          end else if (index_edge) begin
            idx_cnt_d = idx_cnt_q + IDX_W'(1);
            if (idx_cnt_q == IDX_W'(INDEX_TIMEOUT - 1)) begin
              err_rnf_d = 1'b1;
              state_d   = S_FINISH;
            end
          end
        end
        S_XFER: begin
          if (!fd_ready) begin
            err_nr_d = 1'b1;
            drq_d    = 1'b0;
            state_d  = S_FINISH;
          end else begin
            if (data_ack) drq_d = 1'b0;
            if (deliver) begin
              // An unacknowledged byte is overwritten; the consumer learns via err_lost.
              if (drq_q && !data_ack) err_lost_d = 1'b1;
              drq_d      = 1'b1;
              img_addr_d = base + 20'(offset_q);
              offset_d   = offset_q + OFF_W'(1);
              if (last_byte) state_d = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!fd_ready) begin
            err_nr_d = 1'b1;
            drq_d    = 1'b0;
            state_d  = S_FINISH;
          end else if (data_ack) begin
            drq_d   = 1'b0;
            state_d = S_FINISH;
          end else if (fd_dclk_en) begin
            err_lost_d = 1'b1;
            drq_d      = 1'b0;
            state_d    = S_FINISH;
          end
        end
        S_FINISH: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          drq_d   = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q    <= S_IDLE;
      trk_q      <= '0;
      sec_q      <= '0;
      side_q     <= 1'b0;
      busy_q     <= 1'b0;
      drq_q      <= 1'b0;
      img_addr_q <= '0;
      done_q     <= 1'b0;
      err_rnf_q  <= 1'b0;
      err_lost_q <= 1'b0;
      err_nr_q   <= 1'b0;
      offset_q   <= '0;
      idx_cnt_q  <= '0;
      idx_q      <= 1'b1;
      hdr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      trk_q      <= trk_d;
      sec_q      <= sec_d;
      side_q     <= side_d;
      busy_q     <= busy_d;
      drq_q      <= drq_d;
      img_addr_q <= img_addr_d;
      done_q     <= done_d;
      err_rnf_q  <= err_rnf_d;
      err_lost_q <= err_lost_d;
      err_nr_q   <= err_nr_d;
      offset_q   <= offset_d;
      idx_cnt_q  <= idx_cnt_d;
      idx_q      <= fd_index;
      hdr_q      <= fd_sector_hdr;
    end
  end

  assign busy         = busy_q;
  assign drq          = drq_q;
  assign img_addr     = img_addr_q;
  assign done         = done_q;
  assign err_rnf      = err_rnf_q;
  assign err_lost     = err_lost_q;
  assign err_notready = err_nr_q;

endmodule

// File: tb/tb_fdc_sector_reader.sv
// Scoreboard bench for fdc_sector_reader: stimulus queues expected byte addresses and
// completion status, a negedge monitor pops and compares whenever the DUT presents them.
module tb_fdc_sector_reader;

  localparam int M_DELAY4 = 0;  // ack 4 clks after each drq
  localparam int M_NONE   = 1;  // never ack
  localparam int M_COIN   = 2;  // ack together with the next byte clock

  typedef struct packed {
    logic rnf;
    logic lost;
    logic nr;
  } status_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_start, cmd_abort, cmd_side;
  logic [6:0]  cmd_track, fd_track;
  logic [3:0]  cmd_sector, fd_sector;
  logic        fd_ready, fd_dclk_en, fd_sector_hdr, fd_sector_data, fd_index;
  logic        busy, drq, data_ack, done, err_rnf, err_lost, err_notready;
  logic [19:0] img_addr;

  int      exp_addr_q[$];
  status_t exp_done_q[$];
  int      total = 0;
  int      bad = 0;
  int      done_cnt = 0;
  logic        drq_prev;
  logic [19:0] addr_prev;

  fdc_sector_reader dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .cmd_track(cmd_track), .cmd_sector(cmd_sector), .cmd_side(cmd_side),
    .fd_ready(fd_ready), .fd_dclk_en(fd_dclk_en), .fd_track(fd_track),
    .fd_sector(fd_sector), .fd_sector_hdr(fd_sector_hdr),
    .fd_sector_data(fd_sector_data), .fd_index(fd_index), .busy(busy), .drq(drq),
    .data_ack(data_ack), .img_addr(img_addr), .done(done), .err_rnf(err_rnf),
    .err_lost(err_lost), .err_notready(err_notready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a byte is presented when drq rises or the address moves while drq is held.
  always @(negedge clk) begin
    if (!reset) begin
      if (drq && (!drq_prev || img_addr != addr_prev)) begin
        if (exp_addr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL drq_unexpected: got addr 0x%0h with no byte expected", img_addr);
        end else begin
          check("img_addr", 32'(img_addr), exp_addr_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        check("busy_at_done", 32'(busy), 32'd0);
        if (exp_done_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_unexpected: got done with status %b", {err_rnf, err_lost, err_notready});
        end else begin
          check("done_status", 32'({err_rnf, err_lost, err_notready}), 32'(exp_done_q.pop_front()));
        end
      end
    end
    drq_prev  <= drq;
    addr_prev <= img_addr;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic issue(input logic [6:0] t, input logic [3:0] s, input logic sd);
    cmd_track = t; cmd_sector = s; cmd_side = sd; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic push_sector(input int base, input int n);
    for (int i = 0; i < n; i++) exp_addr_q.push_back(base + i);
  endtask

  task automatic header(input logic [6:0] t, input logic [3:0] s);
    fd_track = t; fd_sector = s; fd_sector_hdr = 1'b1;
    ticks(3);
    fd_sector_hdr = 1'b0;
    ticks(3);
  endtask

  // Data window with one byte clock every 8 cycles; checks look at the state left by the previous edge.
  task automatic data_window(input int mode, input int n, input bit abort_last);
    fd_sector_data = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      for (int t = 0; t < 8; t++) begin
        fd_dclk_en = (t == 0);
        data_ack   = (mode == M_DELAY4 && t == 5) ||
                     (mode == M_COIN && ((t == 0 && i > 0) || (t == 4 && i == n - 1)));
        cmd_abort  = abort_last && i == n - 1 && t == 2;
        if (mode == M_COIN && t == 0 && i > 0) check("drq_held", 32'(drq), 32'd1);
        if (mode == M_NONE && t == 1 && i < 2) check("err_lost_early", 32'(err_lost), 32'(i == 1));
        if (abort_last && i == n - 1 && t == 2) check("drq_before_abort", 32'(drq), 32'd1);
        if (abort_last && i == n - 1 && t == 3) begin
          check("busy_after_abort", 32'(busy), 32'd0);
          check("drq_after_abort", 32'(drq), 32'd0);
        end
        tick();
      end
    end
    fd_dclk_en = 1'b0; data_ack = 1'b0; cmd_abort = 1'b0; fd_sector_data = 1'b0;
  endtask

  task automatic gap_clocks();
    for (int g = 0; g < 2; g++) begin
      for (int t = 0; t < 8; t++) begin
        fd_dclk_en = (t == 0);
        tick();
      end
    end
    fd_dclk_en = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int budget, input string name);
    int n = 0;
    while (done_cnt == prev && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(done_cnt != prev), 32'd1);
  endtask

  task automatic full_read(input logic [6:0] t, input logic [3:0] s, input logic sd,
                           input int base, input int mode, input status_t st, input string name);
    int prev = done_cnt;
    push_sector(base, 1024);
    exp_done_q.push_back(st);
    issue(t, s, sd);
    header(t, s);
    data_window(mode, 1024, 1'b0);
    gap_clocks();
    wait_done(prev, 50, name);
    check({name, "_bytes_left"}, 32'(exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    int prev;
    reset = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0; cmd_track = '0; cmd_sector = '0;
    cmd_side = 1'b0; fd_ready = 1'b1; fd_dclk_en = 1'b0; fd_track = '0; fd_sector = '0;
    fd_sector_hdr = 1'b0; fd_sector_data = 1'b0; fd_index = 1'b1; data_ack = 1'b0;
    ticks(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drq", 32'(drq), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_img_addr", 32'(img_addr), 32'd0);
    check("rst_errs", 32'({err_rnf, err_lost, err_notready}), 32'd0);
    reset = 1'b0;
    ticks(2);

    // trk 3 side 1 sec 2: ((3*2+1)*5+2)*1024 = 37*1024 = 0x09400; decoy headers come first.
    prev = done_cnt;
    push_sector(32'h09400, 1024);
    exp_done_q.push_back('{rnf: 1'b0, lost: 1'b0, nr: 1'b0});
    issue(7'd3, 4'd2, 1'b1);
    header(7'd2, 4'd2);
    header(7'd3, 4'd4);
    header(7'd3, 4'd2);
    data_window(M_DELAY4, 1024, 1'b0);
    gap_clocks();
    wait_done(prev, 50, "done_normal");
    check("normal_bytes_left", 32'(exp_addr_q.size()), 32'd0);

    // Drive not ready at command time: busy one cycle then done with err_notready.
    fd_ready = 1'b0;
    prev = done_cnt;
    exp_done_q.push_back('{rnf: 1'b0, lost: 1'b0, nr: 1'b1});
    issue(7'd1, 4'd1, 1'b0);
    tick();
    check("notready_busy_drop", 32'(busy), 32'd0);
    check("notready_done", 32'(done), 32'd1);
    check("notready_flag", 32'(err_notready), 32'd1);
    fd_ready = 1'b1;
    wait_done(prev, 5, "done_notready");

    // Absent sector 7: five revolutions of headers 0..4, done right after the 5th index fall.
    prev = done_cnt;
    exp_done_q.push_back('{rnf: 1'b1, lost: 1'b0, nr: 1'b0});
    issue(7'd2, 4'd7, 1'b0);
    for (int rev = 0; rev < 5; rev++) begin
      for (int s = 0; s < 5; s++) header(7'd2, 4'(s));
      if (rev == 4) begin
        check("busy_before_5th_index", 32'(busy), 32'd1);
        check("no_done_before_5th_index", 32'(done_cnt), 32'(prev));
      end
      fd_index = 1'b0;
      ticks(3);
      fd_index = 1'b1;
    end
    wait_done(prev, 4, "done_rnf");

    // No acks at all: trk 0 side 0 sec 1 -> 0x00400, ends on the first gap byte clock.
    full_read(7'd0, 4'd1, 1'b0, 32'h00400, M_NONE, '{rnf: 1'b0, lost: 1'b1, nr: 1'b0}, "done_lost");

    // Abort after byte 100 of trk 5 side 0 sec 1 -> ((10)*5+1)*1024 = 0x0CC00.
    prev = done_cnt;
    push_sector(32'h0CC00, 100);
    issue(7'd5, 4'd1, 1'b0);
    header(7'd5, 4'd1);
    data_window(M_DELAY4, 100, 1'b1);
    ticks(20);
    check("no_done_after_abort", 32'(done_cnt), 32'(prev));
    check("abort_err_lost_kept_clear", 32'(err_lost), 32'd0);
    // Re-read: trk 10 side 0 sec 4 -> (20*5+4)*1024 = 0x1A000.
    full_read(7'd10, 4'd4, 1'b0, 32'h1A000, M_DELAY4, '{rnf: 1'b0, lost: 1'b0, nr: 1'b0}, "done_after_abort");

    // Ack coincident with every next byte clock: trk 3 side 1 sec 3 -> 38*1024 = 0x09800.
    full_read(7'd3, 4'd3, 1'b1, 32'h09800, M_COIN, '{rnf: 1'b0, lost: 1'b0, nr: 1'b0}, "done_coincident");

    // Ready drops while searching.
    prev = done_cnt;
    exp_done_q.push_back('{rnf: 1'b0, lost: 1'b0, nr: 1'b1});
    issue(7'd4, 4'd0, 1'b0);
    ticks(3);
    fd_ready = 1'b0;
    tick();
    fd_ready = 1'b1;
    wait_done(prev, 5, "done_ready_drop");

    // Reset in the middle of a transfer: back to the reset state with no done pulse.
    prev = done_cnt;
    push_sector(32'h0A000, 3);
    issue(7'd4, 4'd0, 1'b0);
    header(7'd4, 4'd0);
    data_window(M_DELAY4, 3, 1'b0);
    reset = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_img_addr", 32'(img_addr), 32'd0);
    reset = 1'b0;
    ticks(10);
    check("midrst_no_done", 32'(done_cnt), 32'(prev));

    check("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
    check("done_queue_empty", 32'(exp_done_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
